// File: rtl/pattern_loader.sv
// pattern_loader: on a rising edge of load_req, clears every board row, then
// writes the selected 4-row seed pattern at (ORG_ROW, ORG_COL). The board is
// written through a one-row-per-cycle port. busy holds the update engine off
// while the load is in progress.
module pattern_loader #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int ORG_ROW = 6,
  parameter int ORG_COL = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_req,
  input  logic [1:0]              pattern_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    wr_en,
  output logic [$clog2(ROWS)-1:0] wr_addr,
  output logic [COLS-1:0]         wr_data,
  output logic [1:0]              cur_pattern
);

  localparam int AW = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic            req_q_r;
  logic [AW-1:0]   cnt_r;
  logic [1:0]      k_r;
  logic [6:0]      mask_s;
  logic [COLS-1:0] row_data_s;

  // Seed pattern table: 7-bit mask for pattern 'code', pattern row 'k'.
  // Bit j of the result is column offset j from the origin column.
  function automatic logic [6:0] pattern_mask(input logic [1:0] code, input logic [1:0] k);
    logic [6:0] m;
    case ({code, k})
      4'b00_00: m = 7'h02;  // glider
      4'b00_01: m = 7'h04;
      4'b00_10: m = 7'h07;
      4'b00_11: m = 7'h00;
      4'b01_00: m = 7'h07;  // blinker
      4'b01_01: m = 7'h00;
      4'b01_10: m = 7'h00;
      4'b01_11: m = 7'h00;
      4'b10_00: m = 7'h03;  // beacon
      4'b10_01: m = 7'h01;
      4'b10_10: m = 7'h08;
      4'b10_11: m = 7'h0C;
      4'b11_00: m = 7'h02;  // acorn
      4'b11_01: m = 7'h08;
      4'b11_10: m = 7'h73;
      4'b11_11: m = 7'h00;
      default:  m = 7'h00;
    endcase
    return m;
  endfunction

  // Place the current pattern row into a full board row; all other columns stay 0.
  always_comb begin
    mask_s                     = pattern_mask(cur_pattern, k_r);
    row_data_s                 = '0;
    row_data_s[ORG_COL +: 7]   = mask_s;
  end

  // Load sequencer: edge detect, row clear sweep, pattern write, done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      req_q_r     <= 1'b1;  // a button held through reset must not start a load
      cnt_r       <= '0;
      k_r         <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cur_pattern <= 2'd0;
    end else begin
      req_q_r <= load_req;
      case (state_r)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (load_req && !req_q_r) begin
            state_r     <= CLEAR;
            cur_pattern <= pattern_sel;
            cnt_r       <= '0;
            busy        <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        CLEAR: begin
          busy    <= 1'b1;
          done    <= 1'b0;
          wr_en   <= 1'b1;
          wr_addr <= cnt_r;
          wr_data <= '0;
          if (cnt_r == AW'(ROWS - 1)) begin
            cnt_r   <= '0;
            k_r     <= 2'd0;
            state_r <= WRITE;
          end else begin
            cnt_r <= cnt_r + AW'(1);
          end
        end
        WRITE: begin
          busy    <= 1'b1;
          done    <= 1'b0;
          wr_en   <= 1'b1;
          wr_addr <= AW'(ORG_ROW) + AW'(k_r);
          wr_data <= row_data_s;
          if (k_r == 2'd3) begin
            state_r <= DONE;
          end else begin
            k_r <= k_r + 2'd1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          wr_en   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          wr_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: default 16x16 instance plus a small
// 8x12 instance, with hand-computed row images for each seed pattern.
module tb_pattern_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic [1:0]  pattern_sel;
  logic        busy, done, wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  cur_pattern;

  logic        load_req2;
  logic [1:0]  pattern_sel2;
  logic        busy2, done2, wr_en2;
  logic [2:0]  wr_addr2;
  logic [11:0] wr_data2;
  logic [1:0]  cur_pattern2;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_loader dut (
    .clk(clk), .reset(reset), .load_req(load_req), .pattern_sel(pattern_sel),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cur_pattern(cur_pattern)
  );

  pattern_loader #(.ROWS(8), .COLS(12), .ORG_ROW(4), .ORG_COL(5)) dut_small (
    .clk(clk), .reset(reset), .load_req(load_req2), .pattern_sel(pattern_sel2),
    .busy(busy2), .done(done2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .cur_pattern(cur_pattern2)
  );

  // Full load on the default instance. mode 0: single pulse; mode 1: pattern_sel
  // changed mid-load; mode 2: second edge during CLEAR, request held past done.
  task automatic run_load(input logic [1:0] sel, input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] r2, input logic [15:0] r3, input int mode,
                          input string name);
    logic [15:0] rows [4];
    logic        e_busy, e_done, e_wr;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    @(negedge clk);
    pattern_sel = sel;
    load_req    = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || wr_en !== 1'b0 || done !== 1'b0 || cur_pattern !== sel) begin
      errs++;
      $display("FAIL %s accept: busy=%b wr_en=%b done=%b cur=%0d, required busy=1 wr_en=0 done=0 cur=%0d",
               name, busy, wr_en, done, cur_pattern, sel);
    end
    for (int i = 1; i <= 22; i++) begin
      @(posedge clk); #1;
      e_busy = (i <= 20);
      e_done = (i == 21);
      e_wr   = (i <= 20);
      e_addr = (i <= 16) ? 4'(i - 1) : 4'(6 + i - 17);
      e_data = (i <= 16) ? 16'h0000 : ((i <= 20) ? rows[i - 17] : 16'h0000);
      checks++;
      if (busy !== e_busy || done !== e_done || wr_en !== e_wr || cur_pattern !== sel ||
          (e_wr && (wr_addr !== e_addr || wr_data !== e_data))) begin
        errs++;
        $display("FAIL %s cycle %0d: busy=%b done=%b wr_en=%b addr=%0d data=%h cur=%0d, required busy=%b done=%b wr_en=%b addr=%0d data=%h cur=%0d",
                 name, i, busy, done, wr_en, wr_addr, wr_data, cur_pattern,
                 e_busy, e_done, e_wr, e_addr, e_data, sel);
      end
      if (i == 1) load_req = 1'b0;
      if (mode == 1 && i == 3) pattern_sel = 2'd1;
      if (mode == 2 && i == 5) load_req = 1'b1;
    end
    if (mode == 2) begin
      for (int j = 0; j < 10; j++) begin
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
          errs++;
          $display("FAIL %s held-after-done %0d: busy=%b wr_en=%b done=%b, required 0 0 0",
                   name, j, busy, wr_en, done);
        end
      end
    end
    @(negedge clk);
    load_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load_req = 1'b1; pattern_sel = 2'd0;
    load_req2 = 1'b0; pattern_sel2 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 4'd0 ||
        wr_data !== 16'h0000 || cur_pattern !== 2'd0) begin
      errs++;
      $display("FAIL reset_values: busy=%b done=%b wr_en=%b addr=%0d data=%h cur=%0d, required all 0",
               busy, done, wr_en, wr_addr, wr_data, cur_pattern);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || wr_en !== 1'b0) begin
        errs++;
        $display("FAIL held_through_reset cycle %0d: busy=%b wr_en=%b, required 0 0", i, busy, wr_en);
      end
    end
    @(negedge clk);
    load_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk);
    pattern_sel = 2'd2;
    load_req    = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd10) begin
      errs++;
      $display("FAIL pre_reset_row10: wr_en=%b addr=%0d, required 1 10", wr_en, wr_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 4'd0 ||
        wr_data !== 16'h0000 || cur_pattern !== 2'd0) begin
      errs++;
      $display("FAIL async_reset: busy=%b done=%b wr_en=%b addr=%0d data=%h cur=%0d, required all 0",
               busy, done, wr_en, wr_addr, wr_data, cur_pattern);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
        errs++;
        $display("FAIL no_done_after_reset cycle %0d: done=%b busy=%b wr_en=%b, required 0 0 0",
                 i, done, busy, wr_en);
      end
    end
  endtask

  task automatic test_small_blinker;
    logic        e_busy, e_done, e_wr;
    logic [2:0]  e_addr;
    logic [11:0] e_data;
    @(negedge clk);
    pattern_sel2 = 2'd1;
    load_req2    = 1'b1;
    @(posedge clk); #1;
    load_req2 = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      e_busy = (i <= 12);
      e_done = (i == 13);
      e_wr   = (i <= 12);
      e_addr = (i <= 8) ? 3'(i - 1) : 3'(4 + i - 9);
      e_data = (i == 9) ? 12'h0E0 : 12'h000;
      checks++;
      if (busy2 !== e_busy || done2 !== e_done || wr_en2 !== e_wr || cur_pattern2 !== 2'd1 ||
          (e_wr && (wr_addr2 !== e_addr || wr_data2 !== e_data))) begin
        errs++;
        $display("FAIL small_blinker cycle %0d: busy=%b done=%b wr_en=%b addr=%0d data=%h cur=%0d, required busy=%b done=%b wr_en=%b addr=%0d data=%h cur=1",
                 i, busy2, done2, wr_en2, wr_addr2, wr_data2, cur_pattern2,
                 e_busy, e_done, e_wr, e_addr, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    run_load(2'd0, 16'h0020, 16'h0040, 16'h0070, 16'h0000, 0, "glider");
    run_load(2'd3, 16'h0020, 16'h0080, 16'h0730, 16'h0000, 1, "acorn_sel_change");
    run_load(2'd1, 16'h0070, 16'h0000, 16'h0000, 16'h0000, 2, "blinker_edge_in_clear");
    run_load(2'd2, 16'h0030, 16'h0010, 16'h0080, 16'h00C0, 0, "beacon_second_load");
    test_reset_mid_load();
    run_load(2'd0, 16'h0020, 16'h0040, 16'h0070, 16'h0000, 0, "glider_after_reset");
    test_small_blinker();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
